// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator and its
// per-axis counters.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    function automatic int total(input int active, input int fp,
                                 input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a wrapping position counter with registered sync decode.
// The horizontal and vertical axes are both instances of this block.
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA640_H_ACTIVE,
    parameter int FP     = VGA640_H_FP,
    parameter int SYNC   = VGA640_H_SYNC,
    parameter int BP     = VGA640_H_BP,
    parameter int POL    = 0,
    localparam int TOTAL = total(ACTIVE, FP, SYNC, BP),
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END   = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG  = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END  = W'(ACTIVE + FP + SYNC);
    localparam logic         ASSERTED  = 1'(POL);

    logic [W-1:0] count_d, count_q;
    logic         sync_d, sync_q;
    logic         terminal;

    // Decode is taken from the next count so sync lines up with the count
    // register it is presented alongside.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        count_d  = count_q;
        terminal = (count_q == LAST);
        wrap     = terminal & inc & ~clr;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = terminal ? '0 : count_q + W'(1);
        end
        active = (count_d < ACT_END);
        sync_d = (count_d >= SYNC_BEG && count_d < SYNC_END) ? ASSERTED : ~ASSERTED;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sync_q  <= ~ASSERTED;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, data-enable, blanking,
// row/column position and line/frame strobes, gated by a pixel clock enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    localparam int H_TOTAL   = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL   = total(V_ACTIVE, V_FP, V_SYNC, V_BP)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_ce,
    input  logic                       en,
    input  logic                       restart,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       de,
    output logic                       vblank,
    output logic [$clog2(H_TOTAL)-1:0] col,
    output logic [$clog2(V_TOTAL)-1:0] row,
    output logic                       line_start,
    output logic                       frame_start
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
    end
    if (!(H_SYNC_POL inside {0, 1}) || !(V_SYNC_POL inside {0, 1})) begin : g_bad_pol
        $fatal(1, "vga_timing_gen: sync polarity must be 0 or 1");
    end

    logic step;
    logic h_wrap, h_active;
    logic v_wrap, v_active;
    logic first_restart;
    logic restart_seen_d, restart_seen_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;
    logic de_d, de_q;
    logic vblank_d, vblank_q;

    timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (step),
        .clr    (restart),
        .count  (col),
        .wrap   (h_wrap),
        .sync   (hsync),
        .active (h_active)
    );

    timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (h_wrap),
        .clr    (restart),
        .count  (row),
        .wrap   (v_wrap),
        .sync   (vsync),
        .active (v_active)
    );

    // A held restart pulses the strobes only on its first cycle.
    always_comb begin
        step           = pix_ce & en & ~restart;
        restart_seen_d = restart;
        first_restart  = restart & ~restart_seen_q;
        line_start_d   = h_wrap | first_restart;
        frame_start_d  = (h_wrap & v_wrap) | first_restart;
        de_d           = h_active & v_active;
        vblank_d       = ~v_active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            restart_seen_q <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            de_q           <= 1'b1;
            vblank_q       <= 1'b0;
        end else begin
            restart_seen_q <= restart_seen_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            de_q           <= de_d;
            vblank_q       <= vblank_d;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign de          = de_q;
    assign vblank      = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-mode instance under random pix_ce/en/restart
// scored against a linear pixel-index model, plus free-running 640x480 and 800x600 instances.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int ha, hf, hw, hb;
        int va, vf, vw, vb;
        bit hp, vp;
    } mode_t;

    typedef struct packed {
        logic [15:0] col;
        logic [15:0] row;
        logic        hs, vs, de, vb, ls, fs;
    } obs_t;

    localparam mode_t M_SMALL = '{ha: 8, hf: 2, hw: 3, hb: 2, va: 5, vf: 1, vw: 2, vb: 2, hp: 1'b0, vp: 1'b1};
    localparam mode_t M_VGA   = '{ha: 640, hf: 16, hw: 96, hb: 48, va: 480, vf: 10, vw: 2, vb: 33, hp: 1'b0, vp: 1'b0};
    localparam mode_t M_SVGA  = '{ha: 800, hf: 40, hw: 128, hb: 88, va: 600, vf: 1, vw: 4, vb: 23, hp: 1'b1, vp: 1'b1};

    localparam int N_RAND   = 3000;
    localparam int N_DIRECT = 1300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // small instance (15 x 10 raster)
    logic       s_pix_ce = 1'b0, s_en = 1'b0, s_restart = 1'b0;
    logic       s_hsync, s_vsync, s_de, s_vblank, s_ls, s_fs;
    logic [3:0] s_col, s_row;

    // 640x480 defaults, free-running
    logic       d_pix_ce = 1'b1, d_en = 1'b1, d_restart = 1'b0;
    logic       d_hsync, d_vsync, d_de, d_vblank, d_ls, d_fs;
    logic [9:0] d_col, d_row;

    // 800x600 positive syncs, free-running
    logic        w_pix_ce = 1'b1, w_en = 1'b1, w_restart = 1'b0;
    logic        w_hsync, w_vsync, w_de, w_vblank, w_ls, w_fs;
    logic [10:0] w_col;
    logic [9:0]  w_row;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_SYNC_POL(0), .V_SYNC_POL(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_ce(s_pix_ce), .en(s_en), .restart(s_restart),
        .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .vblank(s_vblank),
        .col(s_col), .row(s_row), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .pix_ce(d_pix_ce), .en(d_en), .restart(d_restart),
        .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .vblank(d_vblank),
        .col(d_col), .row(d_row), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP), .H_SYNC(SVGA800_H_SYNC), .H_BP(SVGA800_H_BP),
        .V_ACTIVE(SVGA800_V_ACTIVE), .V_FP(SVGA800_V_FP), .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP),
        .H_SYNC_POL(1), .V_SYNC_POL(1)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .pix_ce(w_pix_ce), .en(w_en), .restart(w_restart),
        .hsync(w_hsync), .vsync(w_vsync), .de(w_de), .vblank(w_vblank),
        .col(w_col), .row(w_row), .line_start(w_ls), .frame_start(w_fs)
    );

    int n_cmp = 0;
    int n_bad = 0;
    obs_t sq[$];

    function automatic string fmt(input obs_t o);
        return $sformatf("col=%0d row=%0d hs=%0b vs=%0b de=%0b vb=%0b ls=%0b fs=%0b",
                         o.col, o.row, o.hs, o.vs, o.de, o.vb, o.ls, o.fs);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got {%s} want {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    // Expected outputs for linear pixel index p within the frame.
    function automatic obs_t ref_obs(input mode_t m, input longint p, input bit ls, input bit fs);
        obs_t o;
        int ht, vt, c, r;
        ht = m.ha + m.hf + m.hw + m.hb;
        vt = m.va + m.vf + m.vw + m.vb;
        c = int'(p % ht);
        r = int'((p / ht) % vt);
        o.col = 16'(c);
        o.row = 16'(r);
        o.hs  = (c >= m.ha + m.hf && c < m.ha + m.hf + m.hw) ? m.hp : ~m.hp;
        o.vs  = (r >= m.va + m.vf && r < m.va + m.vf + m.vw) ? m.vp : ~m.vp;
        o.de  = (c < m.ha) && (r < m.va);
        o.vb  = (r >= m.va);
        o.ls  = ls;
        o.fs  = fs;
        return o;
    endfunction

    function automatic obs_t act_s();
        return '{col: 16'(s_col), row: 16'(s_row), hs: s_hsync, vs: s_vsync,
                 de: s_de, vb: s_vblank, ls: s_ls, fs: s_fs};
    endfunction

    function automatic obs_t act_d();
        return '{col: 16'(d_col), row: 16'(d_row), hs: d_hsync, vs: d_vsync,
                 de: d_de, vb: d_vblank, ls: d_ls, fs: d_fs};
    endfunction

    function automatic obs_t act_w();
        return '{col: 16'(w_col), row: 16'(w_row), hs: w_hsync, vs: w_vsync,
                 de: w_de, vb: w_vblank, ls: w_ls, fs: w_fs};
    endfunction

    // Monitor for the small instance: one expectation per clock once stimulus runs.
    initial begin
        obs_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                exp = sq.pop_front();
                check("small_scoreboard", act_s(), exp);
            end
        end
    end

    task automatic run_small();
        int  frame;
        longint p;
        bit  rs_prev;
        int  rs_hold;
        bit  ls, fs;
        frame   = total(M_SMALL.ha, M_SMALL.hf, M_SMALL.hw, M_SMALL.hb) *
                  total(M_SMALL.va, M_SMALL.vf, M_SMALL.vw, M_SMALL.vb);
        p       = 0;
        rs_prev = 1'b0;
        rs_hold = 0;
        for (int i = 0; i < N_RAND; i++) begin
            if (rs_hold == 0 && $urandom_range(0, 59) == 0) rs_hold = int'($urandom_range(1, 3));
            s_restart = (rs_hold > 0);
            if (rs_hold > 0) rs_hold--;
            s_pix_ce = ($urandom_range(0, 3) != 0);
            s_en     = ($urandom_range(0, 5) != 0);
            ls = 1'b0;
            fs = 1'b0;
            if (s_restart) begin
                p  = 0;
                ls = ~rs_prev;
                fs = ~rs_prev;
            end else if (s_pix_ce && s_en) begin
                p  = (p + 1) % frame;
                ls = (p % total(M_SMALL.ha, M_SMALL.hf, M_SMALL.hw, M_SMALL.hb) == 0);
                fs = (p == 0);
            end
            rs_prev = s_restart;
            sq.push_back(ref_obs(M_SMALL, p, ls, fs));
            @(negedge clk);
        end
        s_pix_ce  = 1'b0;
        s_en      = 1'b0;
        s_restart = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (sq.size() != 0) begin
            n_bad++;
            $display("FAIL small_drain: %0d expectations left, want 0", sq.size());
        end
    endtask

    // Free-running instances advance one pixel per clock from reset release.
    task automatic run_free(input bit wide);
        longint frame;
        int     ht;
        mode_t  m;
        m     = wide ? M_SVGA : M_VGA;
        ht    = total(m.ha, m.hf, m.hw, m.hb);
        frame = longint'(ht) * total(m.va, m.vf, m.vw, m.vb);
        for (int k = 1; k <= N_DIRECT; k++) begin
            @(posedge clk);
            #1;
            if (wide) check("svga_free", act_w(), ref_obs(m, k, (k % ht) == 0, (k % frame) == 0));
            else      check("vga_free",  act_d(), ref_obs(m, k, (k % ht) == 0, (k % frame) == 0));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("small_reset", act_s(), ref_obs(M_SMALL, 0, 1'b0, 1'b0));
        check("vga_reset",   act_d(), ref_obs(M_VGA,   0, 1'b0, 1'b0));
        check("svga_reset",  act_w(), ref_obs(M_SVGA,  0, 1'b0, 1'b0));
        rst_n = 1'b1;
        fork
            run_small();
            run_free(1'b0);
            run_free(1'b1);
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
